// File: rtl/handshake_constant_rep.sv
// Emits REPEAT beats of a fixed constant for every accepted ctrl token.
// Beats carry their index within the burst; the next token may be accepted on the final beat.
module handshake_constant_rep #(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [63:0] CONST_VALUE = 64'd6,
  parameter int          REPEAT      = 1,
  localparam int         IDX_W       = (REPEAT > 1) ? $clog2(REPEAT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_idx,
  output logic                  outs_last,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REPEAT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ctrl_fire;
  logic             outs_fire;

  assign outs       = CONST_VALUE[DATA_WIDTH-1:0];
  assign outs_valid = (state_q == EMIT);
  assign outs_idx   = idx_q;
  assign outs_last  = outs_valid && (idx_q == LAST_IDX);

  // Accepting on the last beat lets bursts run back to back without a bubble.
  assign ctrl_ready = !outs_valid || (outs_ready && outs_last);
  assign ctrl_fire  = ctrl_valid && ctrl_ready;
  assign outs_fire  = outs_valid && outs_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (ctrl_fire) begin
          state_d = EMIT;
          idx_d   = '0;
        end
      end
      EMIT: begin
        if (outs_fire) begin
          if (outs_last) begin
            state_d = ctrl_fire ? EMIT : IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_handshake_constant_rep.sv
// Directed bench for handshake_constant_rep: four instances cover REPEAT=1, 3, 4 and a 2-bit data width.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, before the next rising edge.
module tb_handshake_constant_rep;

  logic clk;
  int   tests_run;
  int   tests_failed;

  // Instance a: REPEAT=1, DATA_WIDTH=32
  logic        a_rst, a_cv, a_cr, a_ov, a_ol, a_or;
  logic [31:0] a_outs;
  logic [0:0]  a_idx;
  // Instance b: REPEAT=3
  logic        b_rst, b_cv, b_cr, b_ov, b_ol, b_or;
  logic [31:0] b_outs;
  logic [1:0]  b_idx;
  // Instance c: REPEAT=4
  logic        c_rst, c_cv, c_cr, c_ov, c_ol, c_or;
  logic [31:0] c_outs;
  logic [1:0]  c_idx;
  // Instance n: DATA_WIDTH=2, REPEAT=1
  logic        n_rst, n_cv, n_cr, n_ov, n_ol, n_or;
  logic [1:0]  n_outs;
  logic [0:0]  n_idx;

  handshake_constant_rep #(.DATA_WIDTH(32), .CONST_VALUE(64'd6), .REPEAT(1)) dut_a (
    .clk(clk), .rst(a_rst), .ctrl_valid(a_cv), .ctrl_ready(a_cr), .outs(a_outs),
    .outs_idx(a_idx), .outs_last(a_ol), .outs_valid(a_ov), .outs_ready(a_or)
  );
  handshake_constant_rep #(.DATA_WIDTH(32), .CONST_VALUE(64'd6), .REPEAT(3)) dut_b (
    .clk(clk), .rst(b_rst), .ctrl_valid(b_cv), .ctrl_ready(b_cr), .outs(b_outs),
    .outs_idx(b_idx), .outs_last(b_ol), .outs_valid(b_ov), .outs_ready(b_or)
  );
  handshake_constant_rep #(.DATA_WIDTH(32), .CONST_VALUE(64'd6), .REPEAT(4)) dut_c (
    .clk(clk), .rst(c_rst), .ctrl_valid(c_cv), .ctrl_ready(c_cr), .outs(c_outs),
    .outs_idx(c_idx), .outs_last(c_ol), .outs_valid(c_ov), .outs_ready(c_or)
  );
  handshake_constant_rep #(.DATA_WIDTH(2), .CONST_VALUE(64'd6), .REPEAT(1)) dut_n (
    .clk(clk), .rst(n_rst), .ctrl_valid(n_cv), .ctrl_ready(n_cr), .outs(n_outs),
    .outs_idx(n_idx), .outs_last(n_ol), .outs_valid(n_ov), .outs_ready(n_or)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset state of all instances; instance a stays in reset so the next test can release it.
  task automatic test_reset;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; n_rst = 1'b0;
    a_cv = 1'b0;  b_cv = 1'b0;  c_cv = 1'b0;  n_cv = 1'b0;
    a_or = 1'b1;  b_or = 1'b1;  c_or = 1'b1;  n_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (k == 0) continue;
      tests_run++;
      if ({a_ov, a_idx, a_ol, a_cr} !== 4'b0001) begin
        tests_failed++;
        $display("FAIL reset_a: {valid,idx,last,ready} got %b expected 0001", {a_ov, a_idx, a_ol, a_cr});
      end
      tests_run++;
      if ({b_ov, b_idx, b_ol, b_cr} !== 5'b00001) begin
        tests_failed++;
        $display("FAIL reset_b: {valid,idx,last,ready} got %b expected 00001", {b_ov, b_idx, b_ol, b_cr});
      end
      tests_run++;
      if ({c_ov, c_idx, c_ol, c_cr} !== 5'b00001) begin
        tests_failed++;
        $display("FAIL reset_c: {valid,idx,last,ready} got %b expected 00001", {c_ov, c_idx, c_ol, c_cr});
      end
      tests_run++;
      if (a_outs !== 32'h0000_0006) begin
        tests_failed++;
        $display("FAIL reset_outs_a: outs got %h expected 00000006", a_outs);
      end
      tests_run++;
      if ({n_ov, n_ol, n_cr, n_outs} !== 5'b00110) begin
        tests_failed++;
        $display("FAIL reset_n: {valid,last,ready,outs} got %b expected 00110", {n_ov, n_ol, n_cr, n_outs});
      end
      $display("[TB] reset cycle %0d a_valid=%b b_valid=%b c_valid=%b n_outs=%b", k, a_ov, b_ov, c_ov, n_outs);
    end
    @(negedge clk);
    b_rst = 1'b1; c_rst = 1'b1; n_rst = 1'b1;
  endtask

  // REPEAT=1: ctrl offered for 10 cycles, the first fire in the very cycle reset is released.
  task automatic test_repeat1_stream;
    logic [3:0] exp_v;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k == 0) begin
        a_rst = 1'b1;
        a_cv  = 1'b1;
        a_or  = 1'b1;
      end
      if (k == 10) a_cv = 1'b0;
      #1;
      exp_v = (k >= 1 && k <= 10) ? 4'b1011 : 4'b0001;
      tests_run++;
      if ({a_ov, a_idx, a_ol, a_cr} !== exp_v) begin
        tests_failed++;
        $display("FAIL repeat1_k%0d: {valid,idx,last,ready} got %b expected %b", k, {a_ov, a_idx, a_ol, a_cr}, exp_v);
      end
      tests_run++;
      if (a_outs !== 32'h0000_0006) begin
        tests_failed++;
        $display("FAIL repeat1_outs_k%0d: outs got %h expected 00000006", k, a_outs);
      end
      $display("[TB] repeat1 k=%0d valid=%b last=%b outs=%h", k, a_ov, a_ol, a_outs);
    end
  endtask

  // REPEAT=3, one token: idx 0,1,2 in consecutive cycles, ready only on the last beat.
  task automatic test_single_burst;
    logic [4:0] exp_tab [5];
    exp_tab = '{5'b0_00_0_1, 5'b1_00_0_0, 5'b1_01_0_0, 5'b1_10_1_1, 5'b0_00_0_1};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b_cv = (k == 0);
      b_or = 1'b1;
      #1;
      tests_run++;
      if ({b_ov, b_idx, b_ol, b_cr} !== exp_tab[k]) begin
        tests_failed++;
        $display("FAIL single_burst_k%0d: {valid,idx,last,ready} got %b expected %b", k, {b_ov, b_idx, b_ol, b_cr}, exp_tab[k]);
      end
      $display("[TB] single_burst k=%0d valid=%b idx=%0d last=%b ready=%b", k, b_ov, b_idx, b_ol, b_cr);
    end
  endtask

  // REPEAT=3, two tokens: second is held off until the idx-2 beat, then six beats with no bubble.
  task automatic test_back_to_back;
    logic [4:0] exp_tab [8];
    exp_tab = '{5'b0_00_0_1, 5'b1_00_0_0, 5'b1_01_0_0, 5'b1_10_1_1,
                5'b1_00_0_0, 5'b1_01_0_0, 5'b1_10_1_1, 5'b0_00_0_1};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b_cv = (k <= 3);
      b_or = 1'b1;
      #1;
      tests_run++;
      if ({b_ov, b_idx, b_ol, b_cr} !== exp_tab[k]) begin
        tests_failed++;
        $display("FAIL back_to_back_k%0d: {valid,idx,last,ready} got %b expected %b", k, {b_ov, b_idx, b_ol, b_cr}, exp_tab[k]);
      end
      $display("[TB] back_to_back k=%0d valid=%b idx=%0d last=%b ctrl_fire=%b", k, b_ov, b_idx, b_ol, b_cv && b_cr);
    end
  endtask

  // REPEAT=3, downstream stalls for 4 cycles on idx 1; the beat must hold and then complete.
  task automatic test_backpressure;
    logic [4:0] exp_tab [9];
    exp_tab = '{5'b0_00_0_1, 5'b1_00_0_0, 5'b1_01_0_0, 5'b1_01_0_0, 5'b1_01_0_0,
                5'b1_01_0_0, 5'b1_01_0_0, 5'b1_10_1_1, 5'b0_00_0_1};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      b_cv = (k == 0);
      b_or = !(k >= 2 && k <= 5);
      #1;
      tests_run++;
      if ({b_ov, b_idx, b_ol, b_cr} !== exp_tab[k]) begin
        tests_failed++;
        $display("FAIL backpressure_k%0d: {valid,idx,last,ready} got %b expected %b", k, {b_ov, b_idx, b_ol, b_cr}, exp_tab[k]);
      end
      tests_run++;
      if (b_outs !== 32'h0000_0006) begin
        tests_failed++;
        $display("FAIL backpressure_outs_k%0d: outs got %h expected 00000006", k, b_outs);
      end
      $display("[TB] backpressure k=%0d outs_ready=%b valid=%b idx=%0d ready=%b", k, b_or, b_ov, b_idx, b_cr);
    end
    b_or = 1'b1;
  endtask

  // REPEAT=4, reset pulsed at idx 2: the burst is dropped, then a fresh token yields idx 0..3.
  task automatic test_reset_mid_burst;
    logic [4:0] exp_tab [12];
    exp_tab = '{5'b0_00_0_1, 5'b1_00_0_0, 5'b1_01_0_0, 5'b1_10_0_0,
                5'b0_00_0_1, 5'b0_00_0_1, 5'b0_00_0_1, 5'b1_00_0_0,
                5'b1_01_0_0, 5'b1_10_0_0, 5'b1_11_1_1, 5'b0_00_0_1};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      c_cv  = (k == 0) || (k == 6);
      c_rst = (k != 3);
      c_or  = 1'b1;
      #1;
      tests_run++;
      if ({c_ov, c_idx, c_ol, c_cr} !== exp_tab[k]) begin
        tests_failed++;
        $display("FAIL reset_mid_burst_k%0d: {valid,idx,last,ready} got %b expected %b", k, {c_ov, c_idx, c_ol, c_cr}, exp_tab[k]);
      end
      $display("[TB] reset_mid_burst k=%0d rst=%b valid=%b idx=%0d last=%b", k, c_rst, c_ov, c_idx, c_ol);
    end
    c_rst = 1'b1;
  endtask

  // DATA_WIDTH=2: constant 6 truncates to 2'b10 on every beat and while idle.
  task automatic test_narrow_width;
    logic [1:0] exp_vl;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cv = (k <= 2);
      n_or = 1'b1;
      #1;
      exp_vl = (k >= 1 && k <= 3) ? 2'b11 : 2'b00;
      tests_run++;
      if ({n_ov, n_ol} !== exp_vl) begin
        tests_failed++;
        $display("FAIL narrow_valid_k%0d: {valid,last} got %b expected %b", k, {n_ov, n_ol}, exp_vl);
      end
      tests_run++;
      if (n_outs !== 2'b10) begin
        tests_failed++;
        $display("FAIL narrow_outs_k%0d: outs got %b expected 10", k, n_outs);
      end
      $display("[TB] narrow k=%0d valid=%b outs=%b", k, n_ov, n_outs);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_repeat1_stream();
    test_single_burst();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_burst();
    test_narrow_width();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
